// File: rtl/kogge_stone_subtractor_seq.sv
// ---------------------------------------------------------------------------
// kogge_stone_subtractor_seq
//
// Purpose
//   Sequential WIDTH-bit subtractor. It computes Diff = A - B one 4-bit nibble
//   per clock, least significant nibble first. Each nibble is added as
//   A + ~B + carry through a two-level 4-bit Kogge-Stone prefix network.
//   The carry (inverted borrow) is held in a register between nibbles.
//   This block is the inverse companion of the ALU adder datapath.
//
// Operation
//   IDLE -> RUN (NIB cycles) -> DONE (held until out_ready) -> IDLE.
//   An operation accepted at edge t shows out_valid from edge t+NIB.
//   With out_ready held high, one operation completes every NIB+2 cycles.
//
// Parameters
//   WIDTH      operand/result width; a multiple of 4 and >= 4
//
// Ports
//   clk        in   1      sole clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      A/B present this cycle
//   in_ready   out  1      block can accept an operation (IDLE, not in reset)
//   A          in   WIDTH  minuend, captured on accept
//   B          in   WIDTH  subtrahend, captured on accept
//   out_valid  out  1      Diff/Borrow(/Overflow) valid (DONE)
//   out_ready  in   1      consumer accepts the result
//   Diff       out  WIDTH  A - B modulo 2^WIDTH
//   Borrow     out  1      1 when unsigned A < B
//   Overflow   out  1      signed overflow; present only with SUB_OVF_EN
//
// Configuration macro
//   SUB_OVF_EN  when defined, adds the Overflow port and its register.
// ---------------------------------------------------------------------------
module kogge_stone_subtractor_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow
`ifdef SUB_OVF_EN
  ,
  output logic             Overflow
`endif
);

  localparam int NIB   = WIDTH / 4;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               borrow_q;
`ifdef SUB_OVF_EN
  logic               ovf_q;
`endif

  // -------------------------------------------------------------------------
  // Nibble operand select: the nibble addressed by the counter.
  // -------------------------------------------------------------------------
  logic [3:0] a_nib, b_nib;

  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int n = 0; n < NIB; n++) begin
      if (cnt_q == CNT_W'(n)) begin
        a_nib = a_q[4*n +: 4];
        b_nib = b_q[4*n +: 4];
      end
    end
  end

  // -------------------------------------------------------------------------
  // 4-bit Kogge-Stone prefix adder computing a_nib + ~b_nib + carry_q.
  // Level 1 combines span 1, level 2 span 2, so g2[i]/p2[i] cover bits [i:0].
  // -------------------------------------------------------------------------
  logic [3:0] nb;
  logic [3:0] g0, p0;
  logic [3:0] g1, p1;
  logic [3:0] g2, p2;
  logic [4:0] c;
  logic [3:0] s;
  logic       cout;

  always_comb begin
    nb = ~b_nib;
    g0 = a_nib & nb;
    p0 = a_nib ^ nb;

    g1 = g0;
    p1 = p0;
    for (int i = 1; i < 4; i++) begin
      g1[i] = g0[i] | (p0[i] & g0[i-1]);
      p1[i] = p0[i] & p0[i-1];
    end

    g2 = g1;
    p2 = p1;
    for (int i = 2; i < 4; i++) begin
      g2[i] = g1[i] | (p1[i] & g1[i-2]);
      p2[i] = p1[i] & p1[i-2];
    end

    // Carry into bit i is the group generate of [i-1:0], or that group
    // propagating the incoming nibble carry.
    c[0] = carry_q;
    for (int i = 1; i < 5; i++) begin
      c[i] = g2[i-1] | (p2[i-1] & carry_q);
    end

    s    = p0 ^ c[3:0];
    cout = c[4];
  end

  // Merge the freshly computed nibble into the result word.
  always_comb begin
    diff_d = diff_q;
    for (int n = 0; n < NIB; n++) begin
      if (cnt_q == CNT_W'(n)) begin
        diff_d[4*n +: 4] = s;
      end
    end
  end

  // -------------------------------------------------------------------------
  // FSM next state and handshake outputs.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Held low while reset is asserted so nothing is offered as accepted.
        in_ready = !rst;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (cnt_q == LAST_NIB) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State and datapath registers.
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b1;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= A;
            b_q     <= B;
            carry_q <= 1'b1;   // carry=1 means "no borrow" into nibble 0
            cnt_q   <= '0;
          end
        end
        RUN: begin
          diff_q  <= diff_d;
          carry_q <= cout;
          if (cnt_q == LAST_NIB) begin
            cnt_q    <= '0;
            borrow_q <= ~cout;
`ifdef SUB_OVF_EN
            // s[3] is the result sign bit produced in this last nibble.
            ovf_q    <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (s[3] != a_q[WIDTH-1]);
`endif
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign Diff   = diff_q;
  assign Borrow = borrow_q;
`ifdef SUB_OVF_EN
  assign Overflow = ovf_q;
`endif

endmodule

// File: tb/tb_kogge_stone_subtractor_seq.sv
// ---------------------------------------------------------------------------
// tb_kogge_stone_subtractor_seq
//
// Self-checking bench for kogge_stone_subtractor_seq (WIDTH=16).
// A monitor samples on the falling edge, queues every accepted operation and
// compares each cycle of out_valid against plain integer arithmetic.
// Directed sequences pin literal results, backpressure, reset abort and
// back-to-back spacing; a randomised phase exercises the handshake.
// Overflow is checked only when SUB_OVF_EN is defined.
// ---------------------------------------------------------------------------
module tb_kogge_stone_subtractor_seq;

  localparam int W   = 16;
  localparam int NIB = W / 4;
  localparam longint SMAX = (longint'(1) << (W - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (W - 1));

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] diff;
  logic         borrow;
`ifdef SUB_OVF_EN
  logic         overflow;
`endif

  kogge_stone_subtractor_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Diff      (diff),
    .Borrow    (borrow)
`ifdef SUB_OVF_EN
    ,
    .Overflow  (overflow)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;
  int acc_total = 0;
  int acc_cycles[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           acc;
  } op_t;
  op_t exp_q[$];

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  // Reference: plain wide-integer subtraction.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                output logic [W-1:0] d, output logic bo, output logic ov);
    longint ua, ub, sa, sb, sd;
    ua = longint'(ma);
    ub = longint'(mb);
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    sd = sa - sb;
    d  = W'(ua - ub);
    bo = (ua < ub);
    ov = (sd > SMAX) || (sd < SMIN);
  endfunction

  // -------------------------------------------------------------------------
  // Monitor / compare process.
  // -------------------------------------------------------------------------
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    logic [W-1:0] ed;
    logic         eb, eo;
    op_t          op;
    if (rst) begin
      exp_q.delete();
      prev_valid = 1'b0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          op = exp_q[0];
          model(op.a, op.b, ed, eb, eo);
          check("mon_diff", 32'(diff), 32'(ed));
          check("mon_borrow", 32'(borrow), 32'(eb));
`ifdef SUB_OVF_EN
          check("mon_overflow", 32'(overflow), 32'(eo));
`endif
          check("mon_in_ready_done", 32'(in_ready), 32'd0);
          if (!prev_valid) check("mon_latency", 32'(cycle - op.acc), 32'(NIB));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        op.a   = a;
        op.b   = b;
        op.acc = cycle + 1;
        exp_q.push_back(op);
        acc_cycles.push_back(cycle + 1);
        acc_total++;
      end
      prev_valid = out_valid;
    end
  end

  // -------------------------------------------------------------------------
  // Directed helpers. All start and end at #2 after a rising edge.
  // -------------------------------------------------------------------------
  task automatic wait_ready(input string name);
    int k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #2;
      k++;
    end
    if (!in_ready) timeout(name);
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic [W-1:0] ed, input logic eb, input logic eo,
                        input int hold);
    int k;
    logic [W-1:0] held;
    wait_ready("ready_wait");
    a = ta;
    b = tb_;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #2;
    in_valid = 1'b0;
    a = W'($urandom);   // ignored outside IDLE
    b = W'($urandom);
    k = 0;
    while (!out_valid && k < 20) begin
      @(posedge clk); #2;
      k++;
    end
    if (!out_valid) begin
      timeout("result_wait");
    end else begin
      check("lit_latency", 32'(k), 32'(NIB));
      check("lit_diff", 32'(diff), 32'(ed));
      check("lit_borrow", 32'(borrow), 32'(eb));
`ifdef SUB_OVF_EN
      check("lit_overflow", 32'(overflow), 32'(eo));
`else
      if (eo) ;  // Overflow port absent in this build
`endif
      held = diff;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #2;
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_diff", 32'(diff), 32'(held));
        check("hold_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #2;
      check("post_valid", 32'(out_valid), 32'd0);
      check("post_in_ready", 32'(in_ready), 32'd1);
    end
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom % 8)
      0:       return '0;
      1:       return '1;
      2:       return W'(1) << (W - 1);
      3:       return ~(W'(1) << (W - 1));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // Reset state.
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow), 32'd0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1 check("rst_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #2;

    // Directed literal cases.
    run_op(16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0, 0);
    run_op(16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 0);
    run_op(16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 0);
    run_op(16'hBEEF, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 0);
    run_op(16'h0000, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 0);
    run_op(16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1, 0);

    // Backpressure: hold DONE for 5 cycles.
    run_op(16'h5A5A, 16'h1234, 16'h4826, 1'b0, 1'b0, 5);

    // Reset in the middle of RUN.
    wait_ready("abort_ready");
    a = 16'hABCD;
    b = 16'h1111;
    in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_borrow", 32'(borrow), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #2;
    run_op(16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 0);

    // Back-to-back with in_valid held high.
    acc_cycles.delete();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_ready("b2b_ready");
      a = W'($urandom);
      b = W'($urandom);
      @(posedge clk); #2;
      if (i == 2) in_valid = 1'b0;
    end
    repeat (10) @(posedge clk);
    #2;
    check("b2b_count", 32'(acc_cycles.size()), 32'd3);
    if (acc_cycles.size() == 3) begin
      check("b2b_gap_0", 32'(acc_cycles[1] - acc_cycles[0]), 32'(NIB + 2));
      check("b2b_gap_1", 32'(acc_cycles[2] - acc_cycles[1]), 32'(NIB + 2));
    end

    // Randomised handshake traffic.
    k = acc_total;
    for (int cyc = 0; cyc < 40000 && (acc_total - k) < 2500; cyc++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      a = rand_operand();
      b = rand_operand();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #2;
    if ((acc_total - k) < 2500) timeout("random_ops");
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
